// File: rtl/blinky_pkg.sv
// Shared constants and types for the blinky LED example.
// The scan-mode constants are only used when BLINKY_SCAN_EN is defined.
package blinky_pkg;

   localparam int unsigned LED_W = 8;

   typedef enum logic {SCAN_UP, SCAN_DOWN} scan_dir_t;

   localparam logic [LED_W-1:0] LEDS_RST_COUNT = 8'h00;
   localparam logic [LED_W-1:0] LEDS_RST_SCAN  = 8'h01;

   // A divide-by-1 prescaler still needs a 1-bit counter to stay legal.
   function automatic int unsigned div_cnt_width(int unsigned clk_div);
      return (clk_div > 1) ? $clog2(clk_div) : 1;
   endfunction

endpackage

// File: rtl/blinky_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 and raises a combinational tick on the last count.
module blinky_tick_gen
   import blinky_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned CNT_W = div_cnt_width(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] div_cnt_q;
   logic [CNT_W-1:0] div_cnt_d;

   // With CLK_DIV=1 the counter sits at 0, so tick is permanently high.
   assign tick = (div_cnt_q == CNT_MAX);

   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      if (tick) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/blinky_soc_top.sv
// LED blinker top: binary count per tick, or a bouncing one-hot scan when
// BLINKY_SCAN_EN is defined.
module blinky_soc_top
   import blinky_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [LED_W-1:0] leds
);

   logic             tick;
   logic [LED_W-1:0] leds_q;
   logic [LED_W-1:0] leds_d;

   blinky_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

`ifdef BLINKY_SCAN_EN
   scan_dir_t dir_q;
   scan_dir_t dir_d;

   // Direction flips on the same edge the end LED lights, so ends are not repeated.
   always_comb begin
      leds_d = leds_q;
      dir_d  = dir_q;
      if (tick) begin
         unique case (dir_q)
            SCAN_UP: begin
               leds_d = leds_q << 1;
               if (leds_d == 8'h80) begin
                  dir_d = SCAN_DOWN;
               end
            end
            SCAN_DOWN: begin
               leds_d = leds_q >> 1;
               if (leds_d == 8'h01) begin
                  dir_d = SCAN_UP;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds_q <= LEDS_RST_SCAN;
         dir_q  <= SCAN_UP;
      end else begin
         leds_q <= leds_d;
         dir_q  <= dir_d;
      end
   end
`else
   always_comb begin
      leds_d = leds_q;
      if (tick) begin
         leds_d = leds_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds_q <= LEDS_RST_COUNT;
      end else begin
         leds_q <= leds_d;
      end
   end
`endif

   assign leds = leds_q;

endmodule

// File: tb/tb_blinky_soc_top.sv
// Scoreboard bench for blinky_soc_top at CLK_DIV = 1, 3 and 4; honours BLINKY_SCAN_EN.
module tb_blinky_soc_top;

   typedef struct packed {
      logic [7:0] e1;
      logic [7:0] e3;
      logic [7:0] e4;
   } exp_t;

`ifdef BLINKY_SCAN_EN
   localparam logic [7:0] RST_VAL = 8'h01;
`else
   localparam logic [7:0] RST_VAL = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] leds1;
   logic [7:0] leds3;
   logic [7:0] leds4;

   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   edge_n   = 0;
   exp_t sb[$];

   blinky_soc_top #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .leds(leds1));
   blinky_soc_top #(.CLK_DIV(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .leds(leds3));
   blinky_soc_top #(.CLK_DIV(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .leds(leds4));

   always #5 clk = ~clk;

   // Pattern after n post-reset edges: n/div completed ticks mapped onto the mode's sequence.
   function automatic logic [7:0] ref_leds(input int n, input int div);
      int k;
      logic [7:0] seq [14];
      k   = n / div;
      seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
              8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
`ifdef BLINKY_SCAN_EN
      return seq[k % 14];
`else
      if (seq[0] == 8'h00) return 8'h00;
      return 8'(k % 256);
`endif
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         edge_n = 0;
      end else begin
         edge_n++;
         sb.push_back('{e1: ref_leds(edge_n, 1), e3: ref_leds(edge_n, 3),
                        e4: ref_leds(edge_n, 4)});
      end
   end

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check("leds_div1", leds1, e.e1);
         check("leds_div3", leds3, e.e3);
         check("leds_div4", leds4, e.e4);
`ifdef BLINKY_SCAN_EN
         check("onehot_div1", 8'($countones(leds1)), 8'd1);
         check("onehot_div4", 8'($countones(leds4)), 8'd1);
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int off;
      int hold;
      int run2;
      rst_n = 1'b0;
      #1;
      check("rst_pre_edge_div1", leds1, RST_VAL);
      check("rst_pre_edge_div3", leds3, RST_VAL);
      check("rst_pre_edge_div4", leds4, RST_VAL);
      #11 rst_n = 1'b1;

      repeat (20) @(posedge clk);
      @(negedge clk);
      off = $urandom_range(1, 3);
      #(off);
      rst_n = 1'b0;
      #1;
      check("rst_async_div1", leds1, RST_VAL);
      check("rst_async_div3", leds3, RST_VAL);
      check("rst_async_div4", leds4, RST_VAL);

      hold = $urandom_range(1, 3);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      check("rst_hold_div4", leds4, RST_VAL);
      #2 rst_n = 1'b1;

      run2 = $urandom_range(270, 300);
      repeat (run2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
